// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one fixed-latency synchronous memory port between the instruction
// fetch (IF) and load/store (LS) requesters. Only one access is in flight at
// a time. The block formats store byte-enables and data, extends load data,
// flags misaligned LS accesses without touching memory, and drives the
// pipeline stall.
//
// Optional build macro: MEM_ARB_FAIRNESS_EN
//   Defined   : a starve counter lets IF win once STARVE_MAX consecutive LS
//               grants have been made while if_req was pending.
//   Undefined : strict LS-over-IF priority; no starve counter is built.
//
// Parameters:
//   MEM_LAT    cycles from the mem_en cycle to mem_rdata valid (>= 1)
//   STARVE_MAX LS grants tolerated while IF waits (fairness build only)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and word-aligned address
//   if_rdata/if_valid               fetched word and completion pulse
//   ls_req/ls_we/ls_size/
//   ls_unsigned/ls_addr/ls_wdata    load/store request and attributes
//   ls_rdata/ls_valid/ls_misalign   load result, completion, misalign flag
//   stall                           pipeline stall (combinational)
//   mem_en/mem_we/mem_addr/
//   mem_be/mem_wdata/mem_rdata      memory port
module mem_port_arbiter #(
   parameter int MEM_LAT = 2
`ifdef MEM_ARB_FAIRNESS_EN
   ,
   parameter int STARVE_MAX = 4
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ls_rdata,
   output logic        ls_valid,
   output logic        ls_misalign,
   output logic        stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t          state_r, state_nx;
   logic [CW-1:0]   cnt_r, cnt_nx;
   logic            owner_ls_r, owner_ls_nx;
   logic            we_r, we_nx;
   logic [1:0]      size_r, size_nx;
   logic [1:0]      lane_r, lane_nx;
   logic            uns_r, uns_nx;
   logic            if_valid_nx, ls_valid_nx, ls_mis_nx;
   logic            mem_en_nx, mem_we_nx;
   logic [31:0]     mem_addr_nx, mem_wdata_nx, if_rdata_nx, ls_rdata_nx;
   logic [3:0]      mem_be_nx;
   logic            grant_ls_s, grant_if_s;
`ifdef MEM_ARB_FAIRNESS_EN
   logic [7:0]      starve_r, starve_nx;
`endif

   // Half needs addr[0]==0, word (and the illegal size 11) needs addr[1:0]==0.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = a[0];
         default: misaligned = (a != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic we, input logic [1:0] size,
                                           input logic [1:0] lane);
      if (!we) begin
         store_be = 4'b1111;
      end else begin
         case (size)
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
         endcase
      end
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   store_data = {4{wd[7:0]}};
         2'b01:   store_data = {2{wd[15:0]}};
         default: store_data = wd;
      endcase
   endfunction

   function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic [1:0] lane,
                                            input logic uns, input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (size)
         2'b00:   load_fmt = {{24{~uns & b[7]}}, b};
         2'b01:   load_fmt = {{16{~uns & h[15]}}, h};
         default: load_fmt = w;
      endcase
   endfunction

   // Grant selection: LS first, unless the fairness counter says IF has waited enough.
   always_comb begin
`ifdef MEM_ARB_FAIRNESS_EN
      grant_if_s = if_req & (~ls_req | (starve_r == 8'(STARVE_MAX)));
`else
      grant_if_s = if_req & ~ls_req;
`endif
      grant_ls_s = ls_req & ~grant_if_s;
   end

   // Next-state and next-output logic; every output register defaults to hold or clear.
   always_comb begin
      state_nx     = state_r;
      cnt_nx       = cnt_r;
      owner_ls_nx  = owner_ls_r;
      we_nx        = we_r;
      size_nx      = size_r;
      lane_nx      = lane_r;
      uns_nx       = uns_r;
      if_valid_nx  = 1'b0;
      ls_valid_nx  = 1'b0;
      ls_mis_nx    = 1'b0;
      mem_en_nx    = 1'b0;
      mem_we_nx    = 1'b0;
      mem_addr_nx  = mem_addr;
      mem_be_nx    = mem_be;
      mem_wdata_nx = mem_wdata;
      if_rdata_nx  = if_rdata;
      ls_rdata_nx  = ls_rdata;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_nx    = starve_r;
`endif
      case (state_r)
         IDLE: begin
`ifdef MEM_ARB_FAIRNESS_EN
            if (!if_req || grant_if_s) begin
               starve_nx = 8'd0;
            end else if (grant_ls_s) begin
               starve_nx = starve_r + 8'd1;
            end else begin
               starve_nx = starve_r;
            end
`endif
            if (grant_ls_s) begin
               owner_ls_nx = 1'b1;
               we_nx       = ls_we;
               size_nx     = ls_size;
               lane_nx     = ls_addr[1:0];
               uns_nx      = ls_unsigned;
               if (misaligned(ls_size, ls_addr[1:0])) begin
                  // Completes without a memory access.
                  state_nx    = DONE;
                  ls_valid_nx = 1'b1;
                  ls_mis_nx   = 1'b1;
                  ls_rdata_nx = 32'd0;
               end else begin
                  state_nx     = ISSUE;
                  mem_en_nx    = 1'b1;
                  mem_we_nx    = ls_we;
                  mem_addr_nx  = {ls_addr[31:2], 2'b00};
                  mem_be_nx    = store_be(ls_we, ls_size, ls_addr[1:0]);
                  mem_wdata_nx = store_data(ls_size, ls_wdata);
               end
            end else if (grant_if_s) begin
               owner_ls_nx = 1'b0;
               we_nx       = 1'b0;
               state_nx    = ISSUE;
               mem_en_nx   = 1'b1;
               mem_we_nx   = 1'b0;
               mem_addr_nx = if_addr;
               mem_be_nx   = 4'b1111;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            if (owner_ls_r && we_r) begin
               state_nx    = DONE;
               ls_valid_nx = 1'b1;
               ls_rdata_nx = 32'd0;
            end else begin
               state_nx = WAIT;
               cnt_nx   = CW'(MEM_LAT);
            end
         end
         WAIT: begin
            cnt_nx = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
               state_nx = DONE;
               if (owner_ls_r) begin
                  ls_valid_nx = 1'b1;
                  ls_rdata_nx = load_fmt(size_r, lane_r, uns_r, mem_rdata);
               end else begin
                  if_valid_nx = 1'b1;
                  if_rdata_nx = mem_rdata;
               end
            end else begin
               state_nx = WAIT;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         owner_ls_r  <= 1'b0;
         we_r        <= 1'b0;
         size_r      <= 2'b00;
         lane_r      <= 2'b00;
         uns_r       <= 1'b0;
         if_valid    <= 1'b0;
         ls_valid    <= 1'b0;
         ls_misalign <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'd0;
         mem_be      <= 4'd0;
         mem_wdata   <= 32'd0;
         if_rdata    <= 32'd0;
         ls_rdata    <= 32'd0;
`ifdef MEM_ARB_FAIRNESS_EN
         starve_r    <= 8'd0;
`endif
      end else begin
         state_r     <= state_nx;
         cnt_r       <= cnt_nx;
         owner_ls_r  <= owner_ls_nx;
         we_r        <= we_nx;
         size_r      <= size_nx;
         lane_r      <= lane_nx;
         uns_r       <= uns_nx;
         if_valid    <= if_valid_nx;
         ls_valid    <= ls_valid_nx;
         ls_misalign <= ls_mis_nx;
         mem_en      <= mem_en_nx;
         mem_we      <= mem_we_nx;
         mem_addr    <= mem_addr_nx;
         mem_be      <= mem_be_nx;
         mem_wdata   <= mem_wdata_nx;
         if_rdata    <= if_rdata_nx;
         ls_rdata    <= ls_rdata_nx;
`ifdef MEM_ARB_FAIRNESS_EN
         starve_r    <= starve_nx;
`endif
      end
   end

   assign stall = ~rst & ((if_req & ~if_valid) | (ls_req & ~ls_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_valid, ls_req, ls_we, ls_unsigned, ls_valid, ls_misalign;
   logic        stall, mem_en, mem_we;
   logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  ls_size;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
      .ls_misalign(ls_misalign), .stall(stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Fixed-latency memory: read data appears MEM_LAT cycles after the mem_en cycle.
   logic [31:0] mem [0:255];
   logic [31:0] pipe [MEM_LAT];
   always @(posedge clk) begin
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hA5A5_5A5A;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[MEM_LAT-1];

   int checks = 0;
   int failures = 0;

   typedef struct packed { logic [31:0] d; logic mis; } ls_exp_t;
   logic [31:0] if_q [$];
   ls_exp_t     ls_q [$];

   int cyc, n_ifv, n_lsv, n_men, if_cyc, ls_cyc, men_cyc, if_at_ls;
   logic        prev_men = 1'b0;
   logic [31:0] men_addr, men_wdata;
   logic [3:0]  men_be;
   logic        men_we;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = -1; n_ifv = 0; n_lsv = 0; n_men = 0;
      if_cyc = -1; ls_cyc = -1; men_cyc = -1; if_at_ls = -1;
   endtask

   // One cycle: sample at negedge and feed the scoreboard.
   task automatic tick();
      ls_exp_t e;
      @(negedge clk);
      cyc++;
      if (mem_en) begin
         chk("mem_en_back_to_back", 32'(prev_men), 32'd0);
         n_men++; men_cyc = cyc;
         men_addr = mem_addr; men_be = mem_be; men_we = mem_we; men_wdata = mem_wdata;
      end
      prev_men = mem_en;
      if (if_valid) begin
         n_ifv++; if_cyc = cyc; if_at_ls = n_lsv;
         if (if_q.size() == 0) chk("if_valid_unexpected", 32'(if_valid), 32'd0);
         else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (ls_valid) begin
         n_lsv++; ls_cyc = cyc;
         if (ls_q.size() == 0) begin
            chk("ls_valid_unexpected", 32'(ls_valid), 32'd0);
         end else begin
            e = ls_q.pop_front();
            chk("ls_rdata", ls_rdata, e.d);
            chk("ls_misalign", 32'(ls_misalign), 32'(e.mis));
         end
      end
   endtask

   task automatic run_ls(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_d, input logic exp_mis, input int exp_cyc,
                         input int exp_men, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      ls_exp_t e;
      @(posedge clk); #1;
      clear_stats();
      ls_req = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns;
      ls_addr = addr; ls_wdata = wdata;
      e.d = exp_d; e.mis = exp_mis;
      ls_q.push_back(e);
      for (int k = 0; k < 20 && n_lsv == 0; k++) begin
         tick();
         if (n_lsv == 0) chk({tag, "_stall"}, 32'(stall), 32'd1);
      end
      chk({tag, "_done"}, 32'(n_lsv), 32'd1);
      chk({tag, "_cycle"}, 32'(ls_cyc), 32'(exp_cyc));
      chk({tag, "_stall_at_valid"}, 32'(stall), 32'd0);
      chk({tag, "_mem_en_count"}, 32'(n_men), 32'(exp_men));
      if (n_men != 0) begin
         chk({tag, "_mem_en_cycle"}, 32'(men_cyc), 32'd1);
         chk({tag, "_mem_addr"}, men_addr, {addr[31:2], 2'b00});
         chk({tag, "_mem_be"}, 32'(men_be), 32'(exp_be));
         chk({tag, "_mem_we"}, 32'(men_we), 32'(we));
         if (we) chk({tag, "_mem_wdata"}, men_wdata, exp_wd);
      end
      @(posedge clk); #1;
      ls_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[8'h40] = 32'h0050_0093;
      mem[8'h80] = 32'h80FF_1234;
      rst = 1'b1; if_req = 1'b1; if_addr = 32'd0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
      ls_addr = 32'd0; ls_wdata = 32'd0;
      clear_stats();

      // Reset state
      repeat (3) tick();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_ls_valid", 32'(ls_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; if_req = 1'b0;

      // Fetch only
      @(posedge clk); #1;
      clear_stats();
      if_req = 1'b1; if_addr = 32'h100;
      if_q.push_back(32'h0050_0093);
      for (int k = 0; k < 20 && n_ifv == 0; k++) begin
         tick();
         if (n_ifv == 0) chk("fetch_stall", 32'(stall), 32'd1);
      end
      chk("fetch_done", 32'(n_ifv), 32'd1);
      chk("fetch_cycle", 32'(if_cyc), 32'd4);
      chk("fetch_stall_at_valid", 32'(stall), 32'd0);
      chk("fetch_mem_en_count", 32'(n_men), 32'd1);
      chk("fetch_mem_en_cycle", 32'(men_cyc), 32'd1);
      chk("fetch_mem_addr", men_addr, 32'h100);
      chk("fetch_mem_be", 32'(men_be), 32'hF);
      chk("fetch_mem_we", 32'(men_we), 32'd0);
      @(posedge clk); #1;
      if_req = 1'b0;

      // Loads, stores, misaligned and illegal-size accesses
      run_ls("lb_s",  1'b0, 2'b00, 1'b0, 32'h203, 32'd0, 32'hFFFF_FF80, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("lb_u",  1'b0, 2'b00, 1'b1, 32'h203, 32'd0, 32'h0000_0080, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("lh_s",  1'b0, 2'b01, 1'b0, 32'h202, 32'd0, 32'hFFFF_80FF, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("lh_u",  1'b0, 2'b01, 1'b1, 32'h200, 32'd0, 32'h0000_1234, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("lb_l1", 1'b0, 2'b00, 1'b0, 32'h201, 32'd0, 32'h0000_0012, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("lw",    1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 32'h80FF_1234, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("l_sz3", 1'b0, 2'b11, 1'b0, 32'h200, 32'd0, 32'h80FF_1234, 1'b0, 4, 1, 4'hF, 32'd0);
      run_ls("sh",    1'b1, 2'b01, 1'b0, 32'h102, 32'hABCD_1234, 32'd0, 1'b0, 2, 1, 4'b1100, 32'h1234_1234);
      run_ls("sb",    1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00EE, 32'd0, 1'b0, 2, 1, 4'b0010, 32'hEEEE_EEEE);
      run_ls("sw",    1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D, 32'd0, 1'b0, 2, 1, 4'b1111, 32'hCAFE_F00D);
      run_ls("mis_w", 1'b0, 2'b10, 1'b0, 32'h006, 32'd0, 32'd0, 1'b1, 1, 0, 4'hF, 32'd0);
      run_ls("mis_h", 1'b1, 2'b01, 1'b0, 32'h003, 32'h1111_2222, 32'd0, 1'b1, 1, 0, 4'hF, 32'd0);

      // IF and six back-to-back LS requests contend
      @(posedge clk); #1;
      clear_stats();
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h200;
      if_q.push_back(32'h0050_0093);
      for (int i = 0; i < 6; i++) begin
         ls_exp_t e;
         e.d = 32'h80FF_1234; e.mis = 1'b0;
         ls_q.push_back(e);
      end
      for (int k = 0; k < 200 && (n_ifv == 0 || n_lsv < 6); k++) begin
         tick();
         if (n_ifv == 0 && !if_valid) chk("arb_if_stall", 32'(stall), 32'd1);
         @(posedge clk); #1;
         if (n_lsv >= 6) ls_req = 1'b0;
         if (n_ifv >= 1) if_req = 1'b0;
      end
      ls_req = 1'b0; if_req = 1'b0;
      chk("arb_ls_count", 32'(n_lsv), 32'd6);
      chk("arb_if_count", 32'(n_ifv), 32'd1);
`ifdef MEM_ARB_FAIRNESS_EN
      chk("arb_if_after_ls", 32'(if_at_ls), 32'd4);
`else
      chk("arb_if_after_ls", 32'(if_at_ls), 32'd6);
`endif
      chk("arb_ls_queue_empty", 32'(ls_q.size()), 32'd0);

      // Reset during WAIT of a read abandons it
      @(posedge clk); #1;
      clear_stats();
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
      repeat (3) tick();
      @(posedge clk); #1;
      rst = 1'b1;
      tick();
      chk("rst_mid_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      tick();
      chk("rst_mid_stall2", 32'(stall), 32'd0);
      chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mid_mem_addr", mem_addr, 32'd0);
      chk("rst_mid_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mid_ls_rdata", ls_rdata, 32'd0);
      chk("rst_mid_if_rdata", if_rdata, 32'd0);
      chk("rst_mid_valids", {29'd0, if_valid, ls_valid, ls_misalign}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ls_req = 1'b0;
      repeat (8) tick();
      chk("rst_no_late_ls_valid", 32'(n_lsv), 32'd0);
      chk("rst_no_late_if_valid", 32'(n_ifv), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between instruction fetch (IF) and load/store (LS) requesters.
- Inputs to the block:
  - LS size and sign information produced by the control decoder (byte/half/word, signed/unsigned).
  - The fetch address from the PC stage.
- What it does:
  - Issues one memory access at a time to a fixed-latency synchronous memory.
  - Formats load data and store byte-enables.
  - Drives the pipeline stall.

Parameters:
- MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; minimum 1.
- STARVE_MAX, 4, consecutive LS grants allowed while if_req is pending (fairness feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch address; must be word-aligned.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle completion pulse for the fetch.
- ls_req  in  1  load/store request; held until ls_valid.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and is treated as word.
- ls_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data, right-justified.
- ls_rdata  out  32  extended load result.
- ls_valid  out  1  one-cycle completion pulse for the load/store.
- ls_misalign  out  1  pulses with ls_valid when the access was misaligned.
- stall  out  1  pipeline stall.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word address, {ls_addr[31:2],2'b00} or the fetch address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset:
  - rst synchronously forces state IDLE.
  - All registered outputs go to 0: if_valid, ls_valid, ls_misalign, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata.
  - Wait counter and starve counter clear.
  - stall = 0 while rst is high.
  - Reset mid-access abandons the access; any late mem_rdata is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitrate among if_req/ls_req and latch the winner, address, size, we and data.
  - No request: stay in IDLE.
  - LS misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with no memory access. In DONE, ls_valid=1, ls_misalign=1, ls_rdata=0.
  - Otherwise: go to ISSUE.
- Arbitration: LS has priority over IF (fairness feature excepted).
- ISSUE (exactly one cycle):
  - mem_en=1; mem_we=ls_we for LS, 0 for IF.
  - Store goes to DONE; read loads counter = MEM_LAT and goes to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata at the clock edge and go to DONE.
- DONE (exactly one cycle):
  - Pulse the owner's valid with its formatted data.
  - Return to IDLE.
  - The requester drops or changes its req on the edge after valid, so IDLE never re-grants a completed request.
- Latency, counted from the IDLE cycle in which req is seen:
  - Read completes with valid in cycle MEM_LAT+2.
  - Store completes in cycle 2.
  - Misaligned access completes in cycle 1.
  - Throughput is one access per latency plus one IDLE cycle.
- Store formatting (lane = addr[1:0]):
  - Byte: be = 1<<lane, wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 or 1100 by addr[1], wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
  - Reads use be = 1111.
- Load formatting: select the lane byte/half, then sign- or zero-extend according to ls_unsigned. Word loads pass through unchanged.
- stall = (if_req & ~if_valid) | (ls_req & ~ls_valid), combinational.
- Simultaneous if_req and ls_req in IDLE: LS wins; IF remains pending and stalled.
- mem_en is never high in two consecutive cycles; mem_en is 0 outside ISSUE.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit-or-wider starve counter increments on each LS grant made while if_req is high.
  - When the counter equals STARVE_MAX and both requests are pending, IF wins.
  - The counter clears on any IF grant or whenever if_req is low in IDLE.
- Undefined: strict LS priority; no counter logic is present.

Test Plan:
- Fetch only, if_addr=0x100, mem_rdata=0x00500093 at MEM_LAT=2 → mem_en pulses in cycle 1 with mem_addr=0x100 and be=1111; if_valid with if_rdata=0x00500093 in cycle 4; stall high in cycles 0-3.
- Load byte signed, ls_addr=0x203, word=0x80FF1234 → mem_addr=0x200; ls_rdata=0xFFFFFF80 (sign-extended byte from lane 3). The same access with ls_unsigned=1 returns 0x00000080.
- Store half, ls_addr=0x102, ls_wdata=0xABCD1234 → mem_we=1, mem_be=1100, mem_wdata=0x12341234; ls_valid in cycle 2.
- Misaligned word load at 0x0006 → mem_en never asserts; ls_valid=1 and ls_misalign=1 in cycle 1.
- if_req and ls_req asserted together, LS reasserted back-to-back 6 times:
  - Without the macro, IF waits until LS stops.
  - With MEM_ARB_FAIRNESS_EN and STARVE_MAX=4, IF is granted after the 4th LS completion.
- rst asserted during WAIT of a read → next cycle all outputs are 0 and state is IDLE; a mem_rdata arriving afterwards produces no valid pulse.
